// File: rtl/fetch_queue.sv
// Purpose : in-order {pc, instr} decoupling FIFO between fetch and decode; flush drops all queued work.
// Latency : 1 cycle from an accepted push to out_valid; the head is read combinationally.
// Backpr. : in_ready = (count != DEPTH) from registered state only; pushes while full and pops while empty are no-ops.
//
// Ports:
//   clk                   system clock, all state updates on the rising edge
//   reset                 asynchronous active-low reset, clears pointers and count
//   in_valid/in_ready     fetch-side handshake; in_pc/in_instr are captured on a push
//   flush                 redirect: empties the queue and suppresses same-cycle push/pop
//   out_valid/out_ready   decode-side handshake; out_pc/out_instr show the head (zero when empty)
//   count                 occupied entries, 0..DEPTH
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push;
    logic          pop;
    logic [63:0]   head_dat;

    // Handshake status depends only on the registered count, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Flush outranks both handshakes.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Empty queue presents zeros so decode sees a nop rather than stale data.
    assign head_dat  = out_valid ? mem_q[rd_ptr_q] : 64'h0;
    assign out_pc    = head_dat[63:32];
    assign out_instr = head_dat[31:0];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH-1 -> 0 wrap is natural overflow.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instr};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queue of {pc, instr}, head at index 0.
    logic [63:0] mq[$];

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_model(input string tag);
        logic [63:0] head;
        head = (mq.size() != 0) ? mq[0] : 64'h0;
        check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() != DEPTH));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        check({tag, ".count"},     64'(count),     64'(mq.size()));
        check({tag, ".out_pc"},    64'(out_pc),    64'(head[63:32]));
        check({tag, ".out_instr"}, 64'(out_instr), 64'(head[31:0]));
    endtask

    // Advance one clock; the model applies the same handshake rules to the
    // inputs held across the edge. Returns 1 ns after the edge.
    task automatic cycle();
        bit p, o;
        p = in_valid && (mq.size() != DEPTH) && !flush;
        o = out_ready && (mq.size() != 0) && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
        end else begin
            if (o) void'(mq.pop_front());
            if (p) mq.push_back({in_pc, in_instr});
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic r, input logic f);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = pc ^ 32'h3c01_0000;
        out_ready = r;
        flush     = f;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_model("drain");
    endtask

    initial begin
        // ---- reset state ----
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.count",     64'(count),     64'd0);
        check("rst.out_pc",    64'(out_pc),    64'd0);
        check("rst.out_instr", 64'(out_instr), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---- single push, visible one cycle later ----
        in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3c01_0001;
        out_ready = 1'b0; flush = 1'b0;
        check("push1.pre_valid", 64'(out_valid), 64'd0);
        cycle();
        in_valid = 1'b0;
        check("push1.out_valid", 64'(out_valid), 64'd1);
        check("push1.out_pc",    64'(out_pc),    64'h3000);
        check("push1.out_instr", 64'(out_instr), 64'h3c01_0001);
        check("push1.count",     64'(count),     64'd1);
        drain();

        // ---- fill past full, then drain in order ----
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
            cycle();
            check_model("fill");
            if (i == 3) begin
                check("fill.in_ready_full", 64'(in_ready), 64'd0);
                check("fill.count_full",    64'(count),    64'd4);
            end
        end
        check("fill.count_after5", 64'(count), 64'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("drain.order_pc", 64'(out_pc), 64'(32'h3000 + 32'(4 * k)));
            cycle();
        end
        check("drain.out_valid", 64'(out_valid), 64'd0);
        check("drain.out_instr", 64'(out_instr), 64'd0);
        out_ready = 1'b0;

        // ---- steady count=2 with simultaneous push/pop across wrap ----
        drive(1'b1, 32'h3000, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h3004, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h3008 + 32'(4 * k), 1'b1, 1'b0);
            check("wrap.head_pc", 64'(out_pc), 64'(32'h3000 + 32'(4 * k)));
            cycle();
            check("wrap.count", 64'(count), 64'd2);
        end
        check_model("wrap.end");
        drain();

        // ---- flush beats same-cycle push and pop ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3100 + 32'(4 * i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h3200, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush.count",     64'(count),     64'd0);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready",  64'(in_ready),  64'd1);
        drive(1'b1, 32'h3400, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        check("flush.next_head", 64'(out_pc), 64'h3400);
        check_model("flush.after");
        drain();

        // ---- full, then pop+push in one cycle: push refused ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3500 + 32'(4 * i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h3600, 1'b1, 1'b0);
        check("fullpp.in_ready", 64'(in_ready), 64'd0);
        cycle();
        check("fullpp.count3", 64'(count), 64'd3);
        drive(1'b1, 32'h3604, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        check("fullpp.count4", 64'(count), 64'd4);
        check_model("fullpp");
        drain();

        // ---- asynchronous reset between edges ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3700 + 32'(4 * i), 1'b0, 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        check("areset.pre_count", 64'(count), 64'd3);
        #3;
        reset = 1'b0;
        #1;
        check("areset.out_valid", 64'(out_valid), 64'd0);
        check("areset.count",     64'(count),     64'd0);
        mq.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h3800, 1'b0, 1'b0);
        cycle();
        in_valid = 1'b0;
        check("areset.first_push", 64'(out_pc), 64'h3800);
        check_model("areset.after");
        drain();

        // ---- randomized traffic against the queue model ----
        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_pc     = $urandom;
            in_instr  = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
